// File: rtl/fft_sdf_stage_ctrl.sv
// Control for one radix-2 SDF FFT stage. Sequences FILL/FIRST/SECOND with input stalls,
// gapless frames and a drain/abort path. Also registers port-A data and decodes the twiddle.
module fft_sdf_stage_ctrl #(
  parameter int DW     = 16,
  parameter int TW     = 8,
  parameter int LOG2D  = 3,
  parameter int STRIDE = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [DW-1:0] data_in_r,
  input  logic [DW-1:0] data_in_i,
  output logic          valid_o,
  output logic [1:0]    state,
  output logic [DW-1:0] data_out_r,
  output logic [DW-1:0] data_out_i,
  output logic [TW-1:0] WN_r,
  output logic [TW-1:0] WN_i,
  output logic          abort_o
);

  localparam int D  = 1 << LOG2D;
  localparam int PW = (LOG2D > 0) ? LOG2D : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(D - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRST  = 2'd1,
    S_SECOND = 2'd2,
    S_FILL   = 2'd3
  } st_e;

  st_e           r_cur, w_cur_nx, w_smp_st;
  logic [PW-1:0] r_cnt, w_cnt_nx, r_oph;
  logic          r_drain, w_drain_nx;
  logic          r_any, w_any_nx;
  logic          w_last, w_vo, w_abort;
  logic [1:0]    r_abort_pipe;

  // r_cur/r_cnt classify the sample arriving this cycle; the output registers
  // below then describe that same sample one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur   <= S_IDLE;
      r_cnt   <= '0;
      r_drain <= 1'b0;
      r_any   <= 1'b0;
    end else begin
      r_cur   <= w_cur_nx;
      r_cnt   <= w_cnt_nx;
      r_drain <= w_drain_nx;
      r_any   <= w_any_nx;
    end
  end

  always_comb begin
    w_cur_nx   = r_cur;
    w_cnt_nx   = r_cnt;
    w_drain_nx = r_drain;
    w_any_nx   = r_any;
    w_smp_st   = r_cur;
    w_vo       = 1'b0;
    w_abort    = 1'b0;
    w_last     = (r_cnt == PH_LAST);
    unique case (r_cur)
      S_IDLE, S_FILL, S_FIRST: begin
        // A valid sample in IDLE is the first FILL sample (r_cnt is 0 in IDLE).
        if (r_cur == S_IDLE) w_smp_st = valid_i ? S_FILL : S_IDLE;
        w_vo = valid_i && (r_cur == S_FIRST);
        if (valid_i) begin
          w_cnt_nx = w_last ? '0 : r_cnt + 1'b1;
          if (w_last)
            w_cur_nx = (r_cur == S_FIRST) ? S_SECOND : S_FIRST;
          else if (r_cur == S_IDLE)
            w_cur_nx = S_FILL;
        end
      end
      S_SECOND: begin
        w_vo       = 1'b1;
        w_cnt_nx   = w_last ? '0 : r_cnt + 1'b1;
        w_drain_nx = r_drain | ~valid_i;
        w_any_nx   = r_any | (valid_i & ~r_drain);
        if (w_last) begin
          w_drain_nx = 1'b0;
          w_any_nx   = 1'b0;
          if (r_drain | ~valid_i) begin
            w_cur_nx = S_IDLE;
            w_abort  = r_any | (valid_i & ~r_drain);
          end else begin
            w_cur_nx = S_FIRST;
          end
        end
      end
      default: ;
    endcase
  end

  // abort_o lands on the first output cycle after the last SECOND output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      r_oph        <= '0;
      valid_o      <= 1'b0;
      data_out_r   <= '0;
      data_out_i   <= '0;
      r_abort_pipe <= '0;
    end else begin
      state        <= w_smp_st;
      r_oph        <= r_cnt;
      valid_o      <= w_vo;
      data_out_r   <= data_in_r;
      data_out_i   <= data_in_i;
      r_abort_pipe <= {r_abort_pipe[0], w_abort};
    end
  end

  assign abort_o = r_abort_pipe[1];

  // Round a Q30 constant to TW-2 fractional bits, half away from zero (values are >= 0).
  function automatic logic [TW-1:0] qs(input logic [63:0] c);
    return TW'(((c << (TW - 2)) + (64'd1 << 29)) >> 30);
  endfunction

  // Quarter-wave cosine table: cos(j*pi/16), j = 0..8.
  function automatic logic [TW-1:0] qw(input logic [3:0] j);
    case (j)
      4'd0:    return qs(64'd1073741824);
      4'd1:    return qs(64'd1053110176);
      4'd2:    return qs(64'd992008094);
      4'd3:    return qs(64'd892783698);
      4'd4:    return qs(64'd759250125);
      4'd5:    return qs(64'd596538995);
      4'd6:    return qs(64'd410903207);
      4'd7:    return qs(64'd209476638);
      default: return '0;
    endcase
  endfunction

  logic [5:0]    w_k;
  logic [4:0]    w_idx;
  logic [3:0]    w_r, w_rc;
  logic [TW-1:0] w_cr, w_cc;

  // Angle index on a 32-point circle (pi/16 steps); quadrant symmetry on the table.
  always_comb begin
    w_k   = (6'(r_oph) * 6'(STRIDE)) & 6'(2 * D - 1);
    w_idx = 5'(w_k << (4 - LOG2D));
    w_r   = {1'b0, w_idx[2:0]};
    w_rc  = 4'd8 - w_r;
    w_cr  = qw(w_r);
    w_cc  = qw(w_rc);
    WN_r  = '0;
    WN_i  = '0;
    if (state == S_SECOND) begin
      unique case (w_idx[4:3])
        2'd0:    begin WN_r = w_cr;  WN_i = -w_cc; end
        2'd1:    begin WN_r = -w_cc; WN_i = -w_cr; end
        2'd2:    begin WN_r = -w_cr; WN_i = w_cc;  end
        default: begin WN_r = w_cc;  WN_i = w_cr;  end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Scoreboard bench for fft_sdf_stage_ctrl: D=8/STRIDE=2/TW=8 instance plus a D=16/STRIDE=1/TW=10 instance.
module tb_fft_sdf_stage_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  localparam real PI = 3.14159265358979;

  logic        v8 = 1'b0, vo8, ab8;
  logic [15:0] dr8 = '0, di8 = '0, or8, oi8;
  logic [1:0]  st8;
  logic [7:0]  wr8, wi8;

  logic        v16 = 1'b0, vo16, ab16;
  logic [15:0] dr16 = '0, di16 = '0, or16, oi16;
  logic [1:0]  st16;
  logic [9:0]  wr16, wi16;

  fft_sdf_stage_ctrl u_dut (
    .clk(clk), .rst(rst), .valid_i(v8), .data_in_r(dr8), .data_in_i(di8),
    .valid_o(vo8), .state(st8), .data_out_r(or8), .data_out_i(oi8),
    .WN_r(wr8), .WN_i(wi8), .abort_o(ab8)
  );

  fft_sdf_stage_ctrl #(.DW(16), .TW(10), .LOG2D(4), .STRIDE(1)) u_d16 (
    .clk(clk), .rst(rst), .valid_i(v16), .data_in_r(dr16), .data_in_i(di16),
    .valid_o(vo16), .state(st16), .data_out_r(or16), .data_out_i(oi16),
    .WN_r(wr16), .WN_i(wi16), .abort_o(ab16)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Twiddle values listed for D=8, STRIDE=2, TW=8.
  logic signed [7:0] WN8R [0:7] = '{64, 45, 0, -45, -64, -45, 0, 45};
  logic signed [7:0] WN8I [0:7] = '{0, -45, -64, -45, 0, 45, 64, 45};

  typedef struct packed {
    logic [1:0]  st;
    logic        vo;
    logic [15:0] dr;
    logic [15:0] di;
    logic [7:0]  wr;
    logic [7:0]  wi;
    logic        ab;
  } exp8_t;
  exp8_t sb[$];

  typedef struct packed {
    logic [1:0] st;
    logic       vo;
    logic [9:0] wr;
    logic [9:0] wi;
  } exp16_t;
  exp16_t sb16[$];

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  task automatic drv(input string tag, input logic v, input logic [1:0] st, input logic vo,
                     input int m, input logic ab);
    exp8_t e;
    v8  = v;
    dr8 = 16'($urandom);
    di8 = 16'($urandom);
    e.st = st; e.vo = vo; e.dr = dr8; e.di = di8; e.ab = ab;
    e.wr = (st == 2'd2) ? WN8R[m] : 8'd0;
    e.wi = (st == 2'd2) ? WN8I[m] : 8'd0;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({tag, ".st"}, 32'(st8), 32'(e.st));
    chk({tag, ".vo"}, 32'(vo8), 32'(e.vo));
    chk({tag, ".dr"}, 32'(or8), 32'(e.dr));
    chk({tag, ".di"}, 32'(oi8), 32'(e.di));
    chk({tag, ".wr"}, 32'(wr8), 32'(e.wr));
    chk({tag, ".wi"}, 32'(wi8), 32'(e.wi));
    chk({tag, ".ab"}, 32'(ab8), 32'(e.ab));
  endtask

  // One frame from IDLE; nv = valid samples at the start of SECOND (< 8).
  task automatic frame(input string nm, input int nv);
    for (int i = 0; i < 8; i++) drv($sformatf("%s.fill%0d", nm, i), 1'b1, 2'd3, 1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) drv($sformatf("%s.first%0d", nm, i), 1'b1, 2'd1, 1'b1, 0, 1'b0);
    for (int i = 0; i < 8; i++) drv($sformatf("%s.sec%0d", nm, i), logic'(i < nv), 2'd2, 1'b1, i, 1'b0);
    drv($sformatf("%s.idle0", nm), 1'b0, 2'd0, 1'b0, 0, logic'(nv > 0));
    drv($sformatf("%s.idle1", nm), 1'b0, 2'd0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.st", 32'(st8), 32'd0);
    chk("rst.vo", 32'(vo8), 32'd0);
    chk("rst.dr", 32'(or8), 32'd0);
    chk("rst.wr", 32'(wr8), 32'd0);
    chk("rst.ab", 32'(ab8), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single frame, then drain with no new samples.
    frame("s1", 0);

    // Three gapless frames.
    for (int i = 0; i < 8; i++) drv($sformatf("b2b.fill%0d", i), 1'b1, 2'd3, 1'b0, 0, 1'b0);
    for (int j = 0; j < 48; j++)
      drv($sformatf("b2b.%0d", j), logic'(j < 40), ((j / 8) % 2 == 1) ? 2'd2 : 2'd1, 1'b1, j % 8, 1'b0);
    drv("b2b.idle", 1'b0, 2'd0, 1'b0, 0, 1'b0);

    // Stalls mid-FILL and mid-FIRST.
    for (int i = 0; i < 4; i++) drv($sformatf("stl.fa%0d", i), 1'b1, 2'd3, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) drv($sformatf("stl.fs%0d", i), 1'b0, 2'd3, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) drv($sformatf("stl.fb%0d", i), 1'b1, 2'd3, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) drv($sformatf("stl.ia%0d", i), 1'b1, 2'd1, 1'b1, 0, 1'b0);
    for (int i = 0; i < 2; i++) drv($sformatf("stl.is%0d", i), 1'b0, 2'd1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) drv($sformatf("stl.ib%0d", i), 1'b1, 2'd1, 1'b1, 0, 1'b0);
    for (int i = 0; i < 8; i++) drv($sformatf("stl.sec%0d", i), 1'b0, 2'd2, 1'b1, i, 1'b0);
    drv("stl.idle", 1'b0, 2'd0, 1'b0, 0, 1'b0);

    // Partial next frame discarded.
    frame("ab3", 3);
    frame("ab7", 7);

    // Async reset mid-SECOND, then replay.
    for (int i = 0; i < 8; i++) drv($sformatf("ar.fill%0d", i), 1'b1, 2'd3, 1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) drv($sformatf("ar.first%0d", i), 1'b1, 2'd1, 1'b1, 0, 1'b0);
    for (int i = 0; i < 3; i++) drv($sformatf("ar.sec%0d", i), 1'b1, 2'd2, 1'b1, i, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("ar.st", 32'(st8), 32'd0);
    chk("ar.vo", 32'(vo8), 32'd0);
    chk("ar.dr", 32'(or8), 32'd0);
    chk("ar.di", 32'(oi8), 32'd0);
    chk("ar.wr", 32'(wr8), 32'd0);
    chk("ar.wi", 32'(wi8), 32'd0);
    chk("ar.ab", 32'(ab8), 32'd0);
    v8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    frame("rep", 0);

    // D=16, STRIDE=1, TW=10 instance.
    for (int i = 0; i < 49; i++) begin
      exp16_t e;
      int m;
      m    = i - 32;
      v16  = (i < 32);
      dr16 = 16'($urandom);
      di16 = 16'($urandom);
      e.st = (i < 16) ? 2'd3 : (i < 32) ? 2'd1 : (i < 48) ? 2'd2 : 2'd0;
      e.vo = (i >= 16) && (i < 48);
      e.wr = (e.st == 2'd2) ? 10'(rnd(256.0 * $cos(PI * m / 16.0))) : 10'd0;
      e.wi = (e.st == 2'd2) ? 10'(rnd(-256.0 * $sin(PI * m / 16.0))) : 10'd0;
      sb16.push_back(e);
      @(posedge clk); #1;
      e = sb16.pop_front();
      chk($sformatf("d16.%0d.st", i), 32'(st16), 32'(e.st));
      chk($sformatf("d16.%0d.vo", i), 32'(vo16), 32'(e.vo));
      chk($sformatf("d16.%0d.wr", i), 32'(wr16), 32'(e.wr));
      chk($sformatf("d16.%0d.wi", i), 32'(wi16), 32'(e.wi));
      if (i == 36) begin
        chk("d16.m4.wr", {22'd0, wr16}, 32'd181);
        chk("d16.m4.wi", {22'd0, wi16}, 32'd843);   // -181 in 10 bits
      end
      if (i == 40) begin
        chk("d16.m8.wr", {22'd0, wr16}, 32'd0);
        chk("d16.m8.wi", {22'd0, wi16}, 32'd768);   // -256 in 10 bits
      end
    end
    v16 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fft_sdf_stage_ctrl.md
# fft_sdf_stage_ctrl

Parametrised control unit for one radix-2 single-path delay-feedback (SDF) FFT stage. It replaces the fixed stage controllers. Delay depth, data width, twiddle width and twiddle stride are parameters. The block adds input stalls, gapless back-to-back frames and a drain/abort path. It registers the input sample toward butterfly port A, reports the stage phase to the butterfly and delay-line muxes, and supplies the twiddle factor.

## Interface
- `DW`, default 16: data width per component (signed).
- `TW`, default 8: twiddle width per component, signed fixed point with 2 integer bits and TW-2 fractional bits.
- `LOG2D`, default 3: log2 of delay depth D. Legal range 0..4, so D = 1..16.
- `STRIDE`, default 2: twiddle angle step in units of pi/D. Legal values 1 or 2.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `valid_i`, in, 1: input sample valid.
- `data_in_r` / `data_in_i`, in, DW each: input sample, signed.
- `valid_o`, out, 1: output sample valid.
- `state`, out, 2: phase of the sample currently on `data_out`. Encodings: IDLE=0, FIRST=1, SECOND=2, FILL=3.
- `data_out_r` / `data_out_i`, out, DW each: registered input, going to butterfly port A.
- `WN_r` / `WN_i`, out, TW each: twiddle factor, signed.
- `abort_o`, out, 1: one-cycle pulse when a partially received next frame is discarded.

## Operation
- Internal counter `ph` (LOG2D bits) gives the position within the current phase, 0..D-1.
- Accepted sample: a cycle with `valid_i`=1 in IDLE, FILL or FIRST, or any cycle in SECOND.
- States:
  - IDLE: waits for input.
  - FILL: first D samples of a stream; data goes into the delay line.
  - FIRST: samples D..2D-1; the butterfly emits sums.
  - SECOND: D cycles; the butterfly emits twiddled differences while the next frame's first half enters.
- Transitions happen when an accepted sample arrives with `ph`=D-1:
  - IDLE to FILL on `valid_i`; that sample takes `ph`=0.
  - FILL to FIRST.
  - FIRST to SECOND.
  - SECOND to FIRST if `valid_i` was 1 on all D SECOND cycles (back-to-back frame, no FILL).
  - SECOND to IDLE otherwise.
- Stall rule: in FILL and FIRST, a `valid_i`=0 cycle holds `ph` and state, and the output for that cycle has `valid_o`=0.
- SECOND is never stalled: `ph` advances every cycle so the delay line drains.
- Drain flag behaviour:
  - Any `valid_i`=0 cycle in SECOND sets the drain flag.
  - Once drain is set, inputs for the rest of SECOND are ignored.
  - At SECOND exit, if drain is set and at least one `valid_i`=1 sample arrived during that SECOND, pulse `abort_o` and go to IDLE.
  - If drain is set and no sample arrived, go to IDLE with no pulse.
  - The drain flag clears on exit.
- Twiddle:
  - Outside SECOND, `WN` = 0 + j0.
  - In SECOND at phase m, let k = (m·STRIDE) mod 2D. Then `WN_r` = round(2^(TW-2)·cos(πk/D)) and `WN_i` = round(-2^(TW-2)·sin(πk/D)).
  - Rounding is half away from zero.
  - Values come from a constant table or a quarter-wave table plus symmetry; no runtime trigonometry.
  - Example, TW=8: m=1 with D=8 and STRIDE=2 gives 45, -45.
- `data_out` = `data_in` registered every cycle, regardless of valid.

## Timing
- Reset values: `state`=IDLE, `ph`=0, drain flag=0, `valid_o`=0, `abort_o`=0, `data_out`=0.
  - `WN`=0 follows from the reset state.
  - Reset mid-frame drops all progress; the first `valid_i` after release starts FILL.
- Latency:
  - 1 cycle from input to `data_out`.
  - `state` and `valid_o` are registered in the same cycle as `data_out` and describe that sample.
  - `WN` is decoded combinationally from registered `state` and `ph`, so it is aligned with `data_out`.
- `valid_o` is 1 for:
  - accepted samples in FIRST;
  - every SECOND cycle, including drain cycles.
- `valid_o` is 0 in IDLE and FILL.
- `abort_o` is asserted in the cycle after the last SECOND cycle.
- Gapless stream of F frames: FILL for D cycles, then alternating FIRST/SECOND for D cycles each. Total is D + 2D·F cycles from the first sample to the last output.
- D=1: every phase lasts one accepted sample, with the same rules.

## Test plan
- D=8, STRIDE=2, gapless 16 samples then `valid_i`=0. Expected sequence: `state` 3×8, 1×8, 2×8, then 0.
  - `valid_o` is high for 16 cycles.
  - `WN` over SECOND: (64,0), (45,-45), (0,-64), (-45,-45), (-64,0), (-45,45), (0,64), (45,45).
- Three back-to-back frames, gapless. Expected: one FILL, then FIRST/SECOND alternating, with no IDLE or FILL between frames.
  - `valid_o` is continuous for 48 cycles after FILL.
- Stall: `valid_i` low for 3 cycles mid-FILL and 2 cycles mid-FIRST. Expected: `ph` holds during the stalls, `valid_o`=0 on the stalled FIRST outputs, and SECOND starts on schedule.
- Partial next frame: 3 valid samples at the start of SECOND, then `valid_i`=0. Expected: SECOND still runs 8 cycles, `abort_o` pulses once, then IDLE.
- Async reset asserted mid-SECOND. Expected: all outputs go to 0 immediately, without waiting for a clock edge.
  - After reset release, a 16-sample stream replays exactly as in the first scenario.
- D=16, STRIDE=1, TW=10. Check: `WN` at m=4 is (181,-181) and at m=8 is (0,-256).
